lfsr_operand_gen: RTL and testbench
===================================

// Module: lfsr_operand_gen
// PURPOSE
//   Pseudo-random operand source for the 10-bit magnitude comparator: supplies the B operand
//   that the player's switch value (A) is compared against. A Fibonacci LFSR is advanced a
//   programmable number of steps per request, and the result is presented under a req/valid/ack
//   handshake. Operand stays stable while valid is high, so the comparator output is glitch-free.
// PARAMETERS
//   WIDTH  10      operand/LFSR width (>=3)
//   TAPS   10'h240 feedback mask, x^10+x^7+1 (bits 9,6); must be primitive for WIDTH
//   SEED   10'h001 reset/fallback LFSR state; must be nonzero
//   DIV_W  4       width of rate input (steps per request = rate+1, 1..2^DIV_W)
// PORTS
//   clk      in   1       system clock, all state on rising edge
//   reset    in   1       asynchronous, active-low reset
//   req      in   1       request new operand; sampled only in IDLE
//   ack      in   1       consumer done with operand; sampled only in PRESENT
//   load     in   1       load seed_in into LFSR; highest priority
//   seed_in  in   WIDTH   seed for load; 0 is replaced by SEED
//   rate     in   DIV_W   extra LFSR steps per request
//   operand  out  WIDTH   registered operand to comparator B input
//   valid    out  1       operand holds a fresh value
//   busy     out  1       high in ADVANCE
// BEHAVIOUR
//   Reset (reset==0, async): lfsr=SEED, operand=0, valid=0, busy=0, cnt=0, state=IDLE.
//   Step: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}; all-zero state never reachable.
//   FSM states IDLE, ADVANCE, PRESENT:
//   - IDLE: req=1 -> ADVANCE, cnt<=rate (rate sampled once here; later changes ignored).
//   - ADVANCE: busy=1; lfsr<=lfsr_next each cycle; cnt!=0 -> cnt<=cnt-1;
//     cnt==0 -> operand<=lfsr_next, valid<=1, state PRESENT.
//   - PRESENT: valid=1, operand frozen; ack=1 -> valid<=0, state IDLE. req ignored.
//   Latency: req sampled at edge k -> valid high after edge k+rate+2's predecessor, i.e.
//     visible from edge k+1+rate (rate+1 LFSR steps, all inside ADVANCE).
//   Same-cycle ack-drop and new req: ack in PRESENT returns to IDLE; req only honoured next
//     cycle from IDLE (minimum 1 idle cycle between operands).
//   load=1 in any state: lfsr<=(seed_in==0 ? SEED : seed_in), valid<=0, busy<=0, state IDLE,
//     operand unchanged; concurrent req/ack in that cycle ignored.
//   ack outside PRESENT ignored; req outside IDLE ignored (not queued).
//   Period: with default TAPS, LFSR sequence repeats every 1023 steps, never emits 0.
//   operand is zero only from reset until the first PRESENT.
// CONFIGURATION
//   LFSR_FREERUN_EN defined: LFSR also steps every cycle in IDLE and PRESENT (load cycle
//     excepted), so operand depends on user timing between requests; ADVANCE unchanged.
//   Not defined: LFSR steps only in ADVANCE; sequence fully deterministic from seed and rates.
// TESTING
//   1 Reset low mid-ADVANCE -> operand=0, valid=0, busy=0 immediately (no clock edge needed).
//   2 Seed 10'h001, rate=0, req 1 cycle -> valid after 1 busy cycle, operand=10'h002.
//   3 Seed 10'h001, rate=6 -> 7 busy cycles, operand=10'h081; hold ack=0 20 cycles ->
//     operand/valid stable; ack -> valid=0 next edge.
//   4 load with seed_in=0 -> lfsr=SEED; next rate=0 request -> operand=10'h002.
//   5 load asserted with req in same IDLE cycle, and load during PRESENT -> state IDLE,
//     valid=0, no ADVANCE started, operand unchanged.
//   6 rate=0, 1023 back-to-back requests from seed 10'h001 (macro undefined) -> all operands
//     nonzero and distinct; request 1023 returns 10'h001.

Source files
------------

// File: rtl/lfsr_operand_gen.sv
// lfsr_operand_gen: pseudo-random B-operand source for the 10-bit magnitude
// comparator. Each request advances a Fibonacci LFSR by rate+1 steps. The
// result is held on operand under a req/valid/ack handshake. operand does not
// change while valid is high, so the comparator sees no glitches.
//
// Optional build macro: LFSR_FREERUN_EN
//   defined     - the LFSR also steps every cycle in IDLE and PRESENT, except
//                 on a load cycle. The operand then depends on how long the
//                 user waits between requests.
//   not defined - the LFSR steps only in ADVANCE. The operand sequence is then
//                 fully determined by the seed and the requested rates.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req; rate captured into the step counter on req
// ADVANCE | stepping the LFSR once per cycle; busy high
// PRESENT | operand frozen, valid high; waiting for ack

module lfsr_operand_gen #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h001,
  parameter int               DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             ack,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [DIV_W-1:0] rate,
  output logic [WIDTH-1:0] operand,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [DIV_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_operand;
  logic             r_valid;
  logic             r_busy;

  logic             w_feedback;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_seed_sel;
  logic             w_cnt_zero;

  // Next LFSR state and seed selection. A zero seed would lock the LFSR at
  // zero, so a zero seed is replaced by SEED.
  always_comb begin
    w_feedback  = ^(r_lfsr & TAPS);
    w_lfsr_next = {r_lfsr[WIDTH-2:0], w_feedback};
    w_seed_sel  = (seed_in == '0) ? SEED : seed_in;
    w_cnt_zero  = (r_cnt == '0);
  end

  // Handshake FSM. load overrides everything. Its own branch does not step the
  // LFSR, even in free-run builds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED;
      r_cnt     <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else if (load) begin
      r_state <= IDLE;
      r_lfsr  <= w_seed_sel;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef LFSR_FREERUN_EN
          r_lfsr <= w_lfsr_next;
`endif
          if (req) begin
            r_state <= ADVANCE;
            r_cnt   <= rate;
            r_busy  <= 1'b1;
          end
        end

        ADVANCE: begin
          r_lfsr <= w_lfsr_next;
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
          end else begin
            r_operand <= w_lfsr_next;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= PRESENT;
          end
        end

        PRESENT: begin
`ifdef LFSR_FREERUN_EN
          r_lfsr <= w_lfsr_next;
`endif
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign operand = r_operand;
  assign valid   = r_valid;
  assign busy    = r_busy;

endmodule

// File: tb/tb_lfsr_operand_gen.sv
// Testbench for lfsr_operand_gen in the default build (free-run disabled).
// The reference model keeps the LFSR state as a plain number. For each request
// it computes the expected operand and pushes it onto a queue. A monitor
// working on the falling clock edge pops the queue on each rising edge of
// valid. It then checks operand against that value on every cycle valid stays
// high.

module tb_lfsr_operand_gen;

  localparam logic [9:0] TAPS = 10'h240;
  localparam logic [9:0] SEED = 10'h001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       ack = 1'b0;
  logic       load = 1'b0;
  logic [9:0] seed_in = '0;
  logic [3:0] rate = '0;
  logic [9:0] operand;
  logic       valid;
  logic       busy;

  lfsr_operand_gen #(
    .WIDTH(10), .TAPS(TAPS), .SEED(SEED), .DIV_W(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .load(load),
    .seed_in(seed_in), .rate(rate), .operand(operand), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  logic [9:0] m_lfsr = SEED;
  logic [9:0] last_op = '0;
  logic [9:0] cur_exp = '0;
  logic       prev_valid = 1'b0;
  bit         track_uniq = 1'b0;
  bit         seen[int];
  logic [9:0] last_dut_op = '0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One LFSR step, computed arithmetically: shift left within 10 bits and
  // append the parity of the tapped bits.
  function automatic logic [9:0] mstep(input logic [9:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = $countones(s & TAPS) % 2;
    return 10'(((v * 2) % 1024) + fb);
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          cur_exp = exp_q.pop_front();
        end
        if (track_uniq) begin
          chk("op_nonzero", int'(operand != 10'h000), 1);
          chk("op_distinct", int'(seen.exists(int'(operand))), 0);
          seen[int'(operand)] = 1'b1;
          last_dut_op = operand;
        end
      end
      if (valid) chk("operand", int'(operand), int'(cur_exp));
      prev_valid = valid;
    end
  end

  // Issue one request. Then count busy cycles until valid, hold for a while,
  // and optionally acknowledge.
  task automatic do_req(input int rv, input int hold, input bit do_ack);
    int nb;
    bit got;
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i <= rv; i++) m_lfsr = mstep(m_lfsr);
    exp_q.push_back(m_lfsr);
    last_op = m_lfsr;
    @(posedge clk); #1;
    req  = 1'b1;
    rate = 4'(rv);
    @(posedge clk); #1;
    req  = 1'b0;
    rate = 4'($urandom);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (valid) got = 1'b1;
    end
    chk("valid_timeout", int'(got), 1);
    chk("busy_cycles", nb, rv + 1);
    repeat (hold) @(posedge clk);
    if (do_ack) begin
      @(posedge clk); #1;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("valid_after_ack", int'(valid), 0);
    end
  endtask

  // Pulse load, optionally together with req. Afterwards check that nothing
  // started and that operand kept its value.
  task automatic do_load(input logic [9:0] s, input bit with_req);
    bit saw;
    saw = 1'b0;
    @(posedge clk); #1;
    load    = 1'b1;
    req     = with_req;
    seed_in = s;
    @(posedge clk); #1;
    load = 1'b0;
    req  = 1'b0;
    m_lfsr = (s == 10'h000) ? SEED : s;
    chk("load_valid", int'(valid), 0);
    chk("load_busy", int'(busy), 0);
    chk("load_operand_kept", int'(operand), int'(last_op));
    repeat (3) begin
      @(negedge clk);
      if (busy || valid) saw = 1'b1;
    end
    chk("load_no_advance", int'(saw), 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_operand", int'(operand), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset seed, rate 0.
    do_req(0, 2, 1);
    chk("rate0_operand", int'(operand), 10'h002);

    // Seed 1, rate 6, long hold with ack low.
    do_load(10'h001, 1'b0);
    do_req(6, 20, 1);
    chk("rate6_operand", int'(operand), 10'h081);

    // A zero seed falls back to SEED.
    do_load(10'h000, 1'b0);
    do_req(0, 1, 1);
    chk("seed0_operand", int'(operand), 10'h002);

    // load together with req in IDLE, then load during PRESENT.
    do_load(10'h155, 1'b1);
    do_req(2, 3, 1'b0);
    do_load(10'h2AA, 1'b0);
    do_req(1, 0, 1);

    // Asynchronous reset in the middle of ADVANCE.
    @(posedge clk); #1;
    req  = 1'b1;
    rate = 4'd15;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_mid_advance", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_operand", int'(operand), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    m_lfsr  = SEED;
    last_op = '0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(0, 0, 1);
    chk("post_reset_operand", int'(operand), 10'h002);

    // Randomized requests, with occasional reloads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 3) == 0) do_load(10'h000, 1'(($urandom_range(0, 1))));
        else do_load(10'($urandom), 1'(($urandom_range(0, 1))));
      end
      do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), 1);
    end

    // Full period: 1023 back-to-back rate-0 requests from seed 1.
    do_load(10'h001, 1'b0);
    track_uniq = 1'b1;
    repeat (1023) do_req(0, 0, 1);
    track_uniq = 1'b0;
    chk("period_wrap", int'(last_dut_op), 10'h001);
    chk("distinct_count", seen.size(), 1023);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
